// File: rtl/id_ex_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_ctrl_stage
// Description : RV32I main control decoder with integrated ALU-control decode.
//               Registers the decoded bundle into the ID/EX pipeline register
//               with stall hold, flush bubble, illegal-opcode detection and a
//               saturating illegal-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_ctrl_stage #(
  parameter int unsigned EN_JALR  = 1,
  parameter int unsigned EN_UTYPE = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      i_instr_d,
  input  logic             i_valid_d,
  input  logic             i_stall_e,
  input  logic             i_flush_e,
  output logic [2:0]       o_imm_src_d,
  output logic             o_reg_write_e,
  output logic [1:0]       o_result_src_e,
  output logic             o_mem_write_e,
  output logic             o_jump_e,
  output logic             o_jalr_e,
  output logic             o_branch_e,
  output logic             o_alu_src_e,
  output logic             o_alu_src_a_pc_e,
  output logic [3:0]       o_alu_ctrl_e,
  output logic             o_valid_e,
  output logic             o_illegal_e,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;
  localparam logic [6:0] c_op_rtype = 7'b0110011;
  localparam logic [6:0] c_op_ialu  = 7'b0010011;
  localparam logic [6:0] c_op_br    = 7'b1100011;
  localparam logic [6:0] c_op_jal   = 7'b1101111;
  localparam logic [6:0] c_op_jalr  = 7'b1100111;
  localparam logic [6:0] c_op_lui   = 7'b0110111;
  localparam logic [6:0] c_op_auipc = 7'b0010111;

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_f7b5;
  logic       w_unused_bits;

  logic       w_legal;
  logic       w_reg_write;
  logic [2:0] w_imm_src;
  logic       w_alu_src;
  logic [1:0] w_result_src;
  logic       w_mem_write;
  logic       w_branch;
  logic       w_jump;
  logic       w_jalr;
  logic       w_src_a_pc;
  logic [1:0] w_alu_op;
  logic [3:0] w_alu_ctrl;

  logic             r_reg_write;
  logic [1:0]       r_result_src;
  logic             r_mem_write;
  logic             r_jump;
  logic             r_jalr;
  logic             r_branch;
  logic             r_alu_src;
  logic             r_src_a_pc;
  logic [3:0]       r_alu_ctrl;
  logic             r_valid;
  logic             r_illegal;
  logic [CNT_W-1:0] r_illegal_cnt;

  assign w_op          = i_instr_d[6:0];
  assign w_f3          = i_instr_d[14:12];
  assign w_f7b5        = i_instr_d[30];
  assign w_unused_bits = ^{i_instr_d[31], i_instr_d[29:15], i_instr_d[11:7]};

  // Main decode: opcode to control bundle; unknown or disabled opcodes are illegal
  always_comb begin
    w_legal      = 1'b1;
    w_reg_write  = 1'b0;
    w_imm_src    = 3'b000;
    w_alu_src    = 1'b0;
    w_result_src = 2'b00;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_jalr       = 1'b0;
    w_src_a_pc   = 1'b0;
    w_alu_op     = 2'b00;
    case (w_op)
      c_op_load: begin
        w_reg_write  = 1'b1;
        w_alu_src    = 1'b1;
        w_result_src = 2'b01;
      end
      c_op_store: begin
        w_imm_src   = 3'b001;
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      c_op_rtype: begin
        w_reg_write = 1'b1;
        w_alu_op    = 2'b10;
      end
      c_op_ialu: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_op    = 2'b10;
      end
      c_op_br: begin
        w_imm_src = 3'b010;
        w_branch  = 1'b1;
        w_alu_op  = 2'b01;
      end
      c_op_jal: begin
        w_reg_write  = 1'b1;
        w_imm_src    = 3'b011;
        w_result_src = 2'b10;
        w_jump       = 1'b1;
      end
      c_op_jalr: begin
        if (EN_JALR != 0) begin
          w_reg_write  = 1'b1;
          w_alu_src    = 1'b1;
          w_result_src = 2'b10;
          w_jump       = 1'b1;
          w_jalr       = 1'b1;
        end else begin
          w_legal = 1'b0;
        end
      end
      c_op_lui: begin
        if (EN_UTYPE != 0) begin
          w_reg_write  = 1'b1;
          w_imm_src    = 3'b100;
          w_result_src = 2'b11;
        end else begin
          w_legal = 1'b0;
        end
      end
      c_op_auipc: begin
        if (EN_UTYPE != 0) begin
          w_reg_write = 1'b1;
          w_imm_src   = 3'b100;
          w_alu_src   = 1'b1;
          w_src_a_pc  = 1'b1;
        end else begin
          w_legal = 1'b0;
        end
      end
      default: w_legal = 1'b0;
    endcase
  end

  // ALU-control decode from ALUOp, funct3 and funct7 bit 5
  always_comb begin
    w_alu_ctrl = 4'b0000;
    case (w_alu_op)
      2'b01:   w_alu_ctrl = 4'b0001;
      2'b10: begin
        case (w_f3)
          3'b000:  w_alu_ctrl = (w_op == c_op_rtype && w_f7b5) ? 4'b0001 : 4'b0000;
          3'b001:  w_alu_ctrl = 4'b0110;
          3'b010:  w_alu_ctrl = 4'b0101;
          3'b011:  w_alu_ctrl = 4'b1001;
          3'b100:  w_alu_ctrl = 4'b0100;
          3'b101:  w_alu_ctrl = w_f7b5 ? 4'b1000 : 4'b0111;
          3'b110:  w_alu_ctrl = 4'b0011;
          default: w_alu_ctrl = 4'b0010;
        endcase
      end
      default: w_alu_ctrl = 4'b0000;
    endcase
  end

  // ID/EX register: reset > flush > stall > load; illegal valid slots become counted bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_write   <= 1'b0;
      r_result_src  <= 2'b00;
      r_mem_write   <= 1'b0;
      r_jump        <= 1'b0;
      r_jalr        <= 1'b0;
      r_branch      <= 1'b0;
      r_alu_src     <= 1'b0;
      r_src_a_pc    <= 1'b0;
      r_alu_ctrl    <= 4'b0000;
      r_valid       <= 1'b0;
      r_illegal     <= 1'b0;
      r_illegal_cnt <= '0;
    end else if (i_flush_e || !i_stall_e) begin
      r_reg_write  <= 1'b0;
      r_result_src <= 2'b00;
      r_mem_write  <= 1'b0;
      r_jump       <= 1'b0;
      r_jalr       <= 1'b0;
      r_branch     <= 1'b0;
      r_alu_src    <= 1'b0;
      r_src_a_pc   <= 1'b0;
      r_alu_ctrl   <= 4'b0000;
      r_valid      <= 1'b0;
      r_illegal    <= 1'b0;
      if (!i_flush_e && i_valid_d) begin
        if (w_legal) begin
          r_reg_write  <= w_reg_write;
          r_result_src <= w_result_src;
          r_mem_write  <= w_mem_write;
          r_jump       <= w_jump;
          r_jalr       <= w_jalr;
          r_branch     <= w_branch;
          r_alu_src    <= w_alu_src;
          r_src_a_pc   <= w_src_a_pc;
          r_alu_ctrl   <= w_alu_ctrl;
          r_valid      <= 1'b1;
        end else begin
          r_illegal <= 1'b1;
          if (r_illegal_cnt != {CNT_W{1'b1}}) begin
            r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  assign o_imm_src_d      = w_legal ? w_imm_src : 3'b000;
  assign o_reg_write_e    = r_reg_write;
  assign o_result_src_e   = r_result_src;
  assign o_mem_write_e    = r_mem_write;
  assign o_jump_e         = r_jump;
  assign o_jalr_e         = r_jalr;
  assign o_branch_e       = r_branch;
  assign o_alu_src_e      = r_alu_src;
  assign o_alu_src_a_pc_e = r_src_a_pc;
  assign o_alu_ctrl_e     = r_alu_ctrl;
  assign o_valid_e        = r_valid;
  assign o_illegal_e      = r_illegal;
  assign o_illegal_cnt    = r_illegal_cnt;

endmodule
`default_nettype wire
